// File: rtl/debounce_pulse_gen_pkg.sv
// Shared definitions for the debounce/pulse block and the downstream 0-9 counter:
// debounce FSM encodings and the ceil-log2 helper used to size counters.
package debounce_pulse_gen_pkg;

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_RISE_WAIT = 2'd1;
  localparam logic [1:0] ST_HIGH      = 2'd2;
  localparam logic [1:0] ST_FALL_WAIT = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE      = ST_IDLE,
    S_RISE_WAIT = ST_RISE_WAIT,
    S_HIGH      = ST_HIGH,
    S_FALL_WAIT = ST_FALL_WAIT
  } db_state_t;

  function automatic int ceil_log2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result = result + 1;
    return result;
  endfunction

endpackage

// File: rtl/debounce_cell.sv
// One debounced input: 2-flop synchronizer, 4-state accept FSM with stability
// counter, registered level and a one-cycle pulse when a 1 is accepted.
module debounce_cell
  import debounce_pulse_gen_pkg::*;
#(
  parameter int   DEBOUNCE_CYCLES = 50000,
  parameter logic INVERT          = 1'b0,
  parameter logic RESET_LEVEL     = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic i_raw,
  output logic o_level,
  output logic o_rise_pulse
);

  localparam int              CNT_W       = ceil_log2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic            SYNC_RST    = RESET_LEVEL ^ INVERT;
  localparam db_state_t       RESET_STATE = RESET_LEVEL ? S_HIGH : S_IDLE;

  logic [1:0]       r_sync;
  logic             w_sample;
  db_state_t        r_state;
  db_state_t        w_state_next;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;
  logic             r_rise;
  logic             w_rise_next;

  // Synchronizer resets to the raw value that corresponds to the idle level.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_sync <= {2{SYNC_RST}};
    else        r_sync <= {r_sync[0], i_raw};
  end

  assign w_sample = r_sync[1] ^ INVERT;

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_rise_next  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_sample) begin
          w_state_next = S_RISE_WAIT;
          w_cnt_next   = '0;
        end
      end
      S_RISE_WAIT: begin
        if (!w_sample) begin
          w_state_next = S_IDLE;
        end else if (r_cnt == CNT_LAST) begin
          w_state_next = S_HIGH;
          w_rise_next  = 1'b1;
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end
      S_HIGH: begin
        if (!w_sample) begin
          w_state_next = S_FALL_WAIT;
          w_cnt_next   = '0;
        end
      end
      S_FALL_WAIT: begin
        if (w_sample) begin
          w_state_next = S_HIGH;
        end else if (r_cnt == CNT_LAST) begin
          w_state_next = S_IDLE;
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= RESET_STATE;
      r_cnt   <= '0;
      r_rise  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_rise  <= w_rise_next;
    end
  end

  assign o_level      = (r_state == S_HIGH) || (r_state == S_FALL_WAIT);
  assign o_rise_pulse = r_rise;

endmodule

// File: rtl/debounce_pulse_gen.sv
// Button/direction front end for the 0-9 counter: debounced press pulses merged
// with an optional free-running auto tick into a single registered count strobe.
module debounce_pulse_gen
  import debounce_pulse_gen_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int AUTO_DIV        = 50000000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_n,
  input  logic dir_sw,
  input  logic auto_en,
  output logic enable,
  output logic A_D,
  output logic btn_level
);

  localparam int               PRE_W    = ceil_log2(AUTO_DIV);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(AUTO_DIV - 1);

  logic             w_btn_level;
  logic             w_btn_rise;
  logic             w_dir_level;
  logic             w_tick;
  logic [PRE_W-1:0] r_presc;
  logic             r_enable;
  logic             r_a_d;
  logic             r_btn_level;

  debounce_cell #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .INVERT         (1'b1),
    .RESET_LEVEL    (1'b0)
  ) u_btn_cell (
    .clk         (clk),
    .reset       (reset),
    .i_raw       (btn_n),
    .o_level     (w_btn_level),
    .o_rise_pulse(w_btn_rise)
  );

  debounce_cell #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .INVERT         (1'b0),
    .RESET_LEVEL    (1'b1)
  ) u_dir_cell (
    .clk         (clk),
    .reset       (reset),
    .i_raw       (dir_sw),
    .o_level     (w_dir_level),
    .o_rise_pulse()
  );

  // Gating with auto_en means dropping it mid-period can never fire a tick.
  assign w_tick = auto_en && (r_presc == PRE_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                r_presc <= '0;
    else if (!auto_en || w_tick) r_presc <= '0;
    else                       r_presc <= r_presc + 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_enable    <= 1'b0;
      r_a_d       <= 1'b1;
      r_btn_level <= 1'b0;
    end else begin
      r_enable    <= w_btn_rise | w_tick;
      r_a_d       <= w_dir_level;
      r_btn_level <= w_btn_level;
    end
  end

  assign enable    = r_enable;
  assign A_D       = r_a_d;
  assign btn_level = r_btn_level;

endmodule

// File: tb/tb_debounce_pulse_gen.sv
// Bench for debounce_pulse_gen: directed scenarios with literal edge positions,
// then random stimulus, all compared every cycle against a run-length model.
`timescale 1ns/1ps
module tb_debounce_pulse_gen;

  localparam int N   = 4;
  localparam int DIV = 10;

  logic clk = 1'b0;
  logic reset;
  logic btn_n;
  logic dir_sw;
  logic auto_en;
  logic enable;
  logic A_D;
  logic btn_level;

  always #5 clk = ~clk;

  debounce_pulse_gen #(
    .DEBOUNCE_CYCLES(N),
    .AUTO_DIV       (DIV)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .btn_n    (btn_n),
    .dir_sw   (dir_sw),
    .auto_en  (auto_en),
    .enable   (enable),
    .A_D      (A_D),
    .btn_level(btn_level)
  );

  // Reference: a level flips once N+1 consecutive synchronized samples disagree
  // with it; outputs appear one register later; auto ticks every DIV enabled cycles.
  logic [1:0] m_bhist, m_dhist;
  int         m_brun, m_drun, m_auto;
  logic       m_blvl, m_dlvl, m_press;
  logic       x_en, x_lvl, x_ad;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_bhist <= 2'b00;
      m_dhist <= 2'b11;
      m_brun  <= 0;
      m_drun  <= 0;
      m_auto  <= 0;
      m_blvl  <= 1'b0;
      m_dlvl  <= 1'b1;
      m_press <= 1'b0;
      x_en    <= 1'b0;
      x_lvl   <= 1'b0;
      x_ad    <= 1'b1;
    end else begin
      if (m_bhist[1] == m_blvl) m_brun <= 0;
      else if (m_brun == N) begin m_blvl <= ~m_blvl; m_brun <= 0; end
      else m_brun <= m_brun + 1;
      m_press <= (m_bhist[1] != m_blvl) && (m_brun == N) && !m_blvl;

      if (m_dhist[1] == m_dlvl) m_drun <= 0;
      else if (m_drun == N) begin m_dlvl <= ~m_dlvl; m_drun <= 0; end
      else m_drun <= m_drun + 1;

      m_bhist <= {m_bhist[0], ~btn_n};
      m_dhist <= {m_dhist[0], dir_sw};
      m_auto  <= auto_en ? m_auto + 1 : 0;
      x_en    <= m_press || (auto_en && (((m_auto + 1) % DIV) == 0));
      x_lvl   <= m_blvl;
      x_ad    <= m_dlvl;
    end
  end

  int   n_cmp = 0;
  int   n_bad = 0;
  logic s_en, s_lvl, s_ad;
  int   pulses, pe, fall, rise, np, low_seen;
  int   pa [0:3];
  int   hb, hd, ha, hr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    s_en  = enable;
    s_lvl = btn_level;
    s_ad  = A_D;
    check("model_enable", {31'd0, s_en}, {31'd0, x_en});
    check("model_btn_level", {31'd0, s_lvl}, {31'd0, x_lvl});
    check("model_A_D", {31'd0, s_ad}, {31'd0, x_ad});
  endtask

  initial begin
    reset = 1'b0; btn_n = 1'b1; dir_sw = 1'b1; auto_en = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_enable", {31'd0, enable}, 0);
    check("reset_A_D", {31'd0, A_D}, 1);
    check("reset_btn_level", {31'd0, btn_level}, 0);
    step();
    reset = 1'b1;
    repeat (10) step();

    // Clean press, then release
    btn_n = 1'b0; pulses = 0; pe = -1; rise = -1;
    for (int k = 0; k < 20; k++) begin
      step();
      if (s_en) begin pulses++; pe = k; end
      if (s_lvl && rise < 0) rise = k;
    end
    check("press_pulse_edge", pe, 7);
    check("press_pulse_count", pulses, 1);
    check("press_level_edge", rise, 7);
    check("press_level_held", {31'd0, s_lvl}, 1);
    btn_n = 1'b1; fall = -1;
    for (int k = 0; k < 12; k++) begin
      step();
      if (!s_lvl && fall < 0) fall = k;
    end
    check("release_level_edge", fall, 7);

    // Bounce: low 3, high 1, then low; final fall is before edge 4
    btn_n = 1'b0; pulses = 0; pe = -1;
    for (int k = 0; k < 20; k++) begin
      step();
      if (s_en) begin pulses++; pe = k; end
      if (k == 2) btn_n = 1'b1;
      if (k == 3) btn_n = 1'b0;
    end
    check("bounce_pulse_edge", pe, 11);
    check("bounce_pulse_count", pulses, 1);
    btn_n = 1'b1;
    repeat (12) step();

    // Auto ticks, held 35 cycles
    auto_en = 1'b1; np = 0;
    for (int k = 0; k < 40; k++) begin
      step();
      if (s_en) begin if (np < 4) pa[np] = k + 1; np++; end
      if (k + 1 == 35) auto_en = 1'b0;
    end
    check("auto35_count", np, 3);
    check("auto35_first", pa[0], 10);
    check("auto35_second", pa[1], 20);
    check("auto35_third", pa[2], 30);
    repeat (3) step();

    // Auto dropped after cycle 25
    auto_en = 1'b1; np = 0;
    for (int k = 0; k < 40; k++) begin
      step();
      if (s_en) begin if (np < 4) pa[np] = k + 1; np++; end
      if (k + 1 == 25) auto_en = 1'b0;
    end
    check("auto25_count", np, 2);
    check("auto25_second", pa[1], 20);
    repeat (3) step();

    // Button rise aligned with the tick at auto edge 10
    auto_en = 1'b1; np = 0; pe = -1;
    for (int k = 0; k < 16; k++) begin
      step();
      if (s_en) begin np++; pe = k + 1; end
      if (k + 1 == 2) btn_n = 1'b0;
    end
    check("coincide_count", np, 1);
    check("coincide_edge", pe, 10);
    auto_en = 1'b0; btn_n = 1'b1;
    repeat (14) step();

    // Direction change and short glitch
    dir_sw = 1'b0; fall = -1;
    for (int k = 0; k < 12; k++) begin
      step();
      if (!s_ad && fall < 0) fall = k;
    end
    check("dir_fall_edge", fall, 7);
    dir_sw = 1'b1;
    repeat (12) step();
    check("dir_restored", {31'd0, s_ad}, 1);
    dir_sw = 1'b0; low_seen = 0;
    for (int k = 0; k < 16; k++) begin
      step();
      if (!s_ad) low_seen = 1;
      if (k == 1) dir_sw = 1'b1;
    end
    check("dir_glitch_rejected", low_seen, 0);

    // Reset in the middle of a press
    btn_n = 1'b0;
    repeat (4) step();
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      check("reset_hold_enable", {31'd0, s_en}, 0);
    end
    reset = 1'b1; pulses = 0; pe = -1;
    for (int k = 0; k < 16; k++) begin
      step();
      if (s_en) begin pulses++; pe = k; end
    end
    check("post_reset_pulse_edge", pe, 7);
    check("post_reset_pulse_count", pulses, 1);
    btn_n = 1'b1;
    repeat (12) step();

    // Random traffic with occasional resets
    hb = 3; hd = 5; ha = 20; hr = 0;
    for (int c = 0; c < 3000; c++) begin
      if (hb == 0) begin btn_n = ~btn_n; hb = $urandom_range(1, 12); end else hb--;
      if (hd == 0) begin dir_sw = ~dir_sw; hd = $urandom_range(1, 12); end else hd--;
      if (ha == 0) begin auto_en = ~auto_en; ha = $urandom_range(1, 60); end else ha--;
      if (!reset) begin
        if (hr == 0) reset = 1'b1; else hr--;
      end else if ($urandom_range(0, 499) == 0) begin
        reset = 1'b0; hr = $urandom_range(0, 3);
      end
      step();
    end
    reset = 1'b1;
    repeat (4) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/debounce_pulse_gen.md
DEBOUNCE_PULSE_GEN -- requirements
Module: debounce_pulse_gen

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 50000, giving the number of consecutive stable synchronized samples needed to accept a level change (1 ms at 50 MHz); legal range 2..65535.
REQ-002 The block SHALL have parameter AUTO_DIV, default 50000000, giving the auto-count tick period in clk cycles; legal range 2..2^26.
REQ-003 clk  input  1  system clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 btn_n  input  1  raw push-button, asynchronous; 0 = pressed.
REQ-006 dir_sw  input  1  raw direction slide switch, asynchronous; 1 = up, 0 = down.
REQ-007 auto_en  input  1  synchronous level; 1 = free-running auto-count ticks.
REQ-008 enable  output  1  registered single-cycle count strobe for the downstream 0-9 counter.
REQ-009 A_D  output  1  registered debounced direction; 1 = up, 0 = down.
REQ-010 btn_level  output  1  registered debounced button state; 1 = pressed.

Function
REQ-011 Each raw input SHALL pass through a 2-flop synchronizer before any other logic; btn_n is inverted after synchronization.
REQ-012 Each debounce cell SHALL be a 4-state FSM: IDLE (accepted 0), RISE_WAIT, HIGH (accepted 1), FALL_WAIT, with a counter of width CeilLog2(DEBOUNCE_CYCLES).
REQ-013 IDLE -> RISE_WAIT with counter cleared when the synchronized sample is 1; HIGH -> FALL_WAIT with counter cleared when the sample is 0; otherwise the state holds.
REQ-014 In RISE_WAIT/FALL_WAIT, a sample equal to the accepted level SHALL return the FSM to IDLE/HIGH respectively; otherwise the counter increments.
REQ-015 When the counter equals DEBOUNCE_CYCLES-1 and the sample still differs from the accepted level, the FSM SHALL move to HIGH/FALL->IDLE respectively; the cell level output SHALL change on that edge.
REQ-016 The button cell SHALL emit a one-cycle rise pulse on the RISE_WAIT->HIGH edge only; there are no pulses on release and no repeat while held.
REQ-017 Latency SHALL be exact: a btn_n falling edge stable before edge 0 makes enable high in the cycle after edge DEBOUNCE_CYCLES+3, for exactly one cycle.
REQ-018 The prescaler SHALL be held at 0 while auto_en=0; while auto_en=1 it counts 0..AUTO_DIV-1, wraps to 0 and raises a tick on the wrap edge.
REQ-019 enable SHALL be the register of (button rise pulse OR tick); coincident sources yield one pulse, never two in consecutive cycles.
REQ-020 A_D SHALL equal the dir_sw cell level; btn_level SHALL equal the button cell level.
REQ-021 A dir_sw change SHALL update A_D DEBOUNCE_CYCLES+3 edges after the raw change; glitches shorter than DEBOUNCE_CYCLES cycles SHALL be fully rejected.
REQ-022 Dropping auto_en mid-period SHALL clear the prescaler on the next edge without producing a tick.

Reset
REQ-023 While reset=0: synchronizer flops = released/up (btn 0, dir 1), button FSM = IDLE, dir FSM = HIGH, counters = 0, prescaler = 0, enable = 0, A_D = 1, btn_level = 0.
REQ-024 Reset asserted mid-debounce SHALL abort with no pulse; a button still held after reset release SHALL produce exactly one pulse DEBOUNCE_CYCLES+3 edges later.

Structure
REQ-025 The CeilLog2 function and FSM state encodings (2-bit localparams) SHALL live in a shared package/include file used by this block and the counter.
REQ-026 One sub-module, debounce_cell (synchronizer, FSM, counter; outputs level and rise_pulse), SHALL be instantiated twice; the prescaler and output registers stay in the top level.

Verification (DEBOUNCE_CYCLES=4, AUTO_DIV=10)
REQ-027 Clean press: btn_n 1->0 held 20 cycles -> enable high for exactly one cycle after edge 7; btn_level 1 from edge 7 to 4+3 edges after release.
REQ-028 Bounce: btn_n low 3 cycles, high 1, low 10 -> no pulse from the first burst; exactly one pulse 7 edges after the final fall.
REQ-029 Auto: auto_en=1 for 35 cycles -> pulses after edges 10, 20 and 30; auto_en dropped at cycle 25 -> no pulse at 30.
REQ-030 Coincidence: button pulse aligned with tick -> single one-cycle enable.
REQ-031 Direction: dir_sw 1->0 -> A_D falls after edge 7; a 2-cycle dir_sw glitch leaves A_D at 1.
REQ-032 Reset mid-RISE_WAIT with btn held -> enable stays 0 during reset; one pulse 7 edges after reset release.
